// File: rtl/data_flow_pipeline.sv
// data_flow_pipeline: a mode-selectable four-operand bitwise function feeding
// a STAGES-deep valid/ready register pipeline. Bubbles collapse under
// backpressure. A saturating counter tracks completed output transfers.
module data_flow_pipeline #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      xfer_count,
  input  logic             count_clr
);

  // Bitwise result for the selected mode; every bit is independent.
  function automatic logic [WIDTH-1:0] calc_f(
    input logic [WIDTH-1:0] fa,
    input logic [WIDTH-1:0] fb,
    input logic [WIDTH-1:0] fc,
    input logic [WIDTH-1:0] fd,
    input logic [1:0]       fm
  );
    logic [WIDTH-1:0] res;
    case (fm)
      2'd0:    res = ~(((fa & fb) | ~fc) & fd);
      2'd1:    res = ((fa & fb) | ~fc) & fd;
      2'd2:    res = ~((fa & fb) | (fc & fd));
      default: res = fa ^ fb ^ fc ^ fd;
    endcase
    return res;
  endfunction

  // Index 0 is the first stage; index STAGES-1 drives the outputs.
  logic [WIDTH-1:0]  data_r [STAGES];
  logic [STAGES-1:0] valid_r;
  logic [STAGES-1:0] load_s;
  logic [WIDTH-1:0]  f_s;
  logic              out_xfer_s;
  logic [15:0]       count_r;

  assign f_s        = calc_f(a, b, c, d, mode);
  assign out_xfer_s = valid_r[STAGES-1] & out_ready;

  // Load enables: a stage may load when it is empty or its successor is moving,
  // so an invalid bubble anywhere ahead lets the upstream stages advance.
  always_comb begin
    load_s = '0;
    load_s[STAGES-1] = ~valid_r[STAGES-1] | out_ready;
    for (int i = STAGES - 2; i >= 0; i--) begin
      load_s[i] = ~valid_r[i] | load_s[i+1];
    end
  end

  // in_ready is held low during reset so nothing is accepted into a clearing pipe.
  assign in_ready = ~rst & load_s[0];

  // Pipeline registers: valid bits follow the load rule, and data only moves
  // when valid data arrives, so an invalid stage never changes the visible out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_r[i] <= '0;
      end
    end else begin
      if (load_s[0]) begin
        valid_r[0] <= in_valid;
        if (in_valid) begin
          data_r[0] <= f_s;
        end else begin
          data_r[0] <= data_r[0];
        end
      end else begin
        valid_r[0] <= valid_r[0];
      end
      for (int i = 1; i < STAGES; i++) begin
        if (load_s[i]) begin
          valid_r[i] <= valid_r[i-1];
          if (valid_r[i-1]) begin
            data_r[i] <= data_r[i-1];
          end else begin
            data_r[i] <= data_r[i];
          end
        end else begin
          valid_r[i] <= valid_r[i];
        end
      end
    end
  end

  // Output transfer counter: clear wins over a simultaneous transfer, and the
  // count sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= 16'h0000;
    end else if (count_clr) begin
      count_r <= 16'h0000;
    end else if (out_xfer_s && (count_r != 16'hFFFF)) begin
      count_r <= count_r + 16'h0001;
    end else begin
      count_r <= count_r;
    end
  end

  assign out        = data_r[STAGES-1];
  assign out_valid  = valid_r[STAGES-1];
  assign xfer_count = count_r;

endmodule

// File: tb/tb_data_flow_pipeline.sv
// Self-checking bench for data_flow_pipeline: directed latency, throughput,
// backpressure, reset and counter saturation steps plus a randomized run,
// all checked against a queue-based reference model.
module tb_data_flow_pipeline;
  localparam int W = 8;
  localparam int S = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  a, b, c, d;
  logic [1:0]    mode;
  logic          in_valid, in_ready;
  logic [W-1:0]  out;
  logic          out_valid, out_ready;
  logic [15:0]   xfer_count;
  logic          count_clr;

  data_flow_pipeline #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .out(out), .out_valid(out_valid),
    .out_ready(out_ready), .xfer_count(xfer_count), .count_clr(count_clr)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] q[$];
  logic [15:0]  mcnt = 16'h0000;
  int           cyc = 0;
  int           n_in = 0;
  int           n_out = 0;
  int           ocyc[$];
  logic [W-1:0] oval[$];
  logic         seen_ir, oxfer;
  logic         hold_pending = 1'b0;
  logic [W-1:0] prev_out;

  // Reference function evaluated bit by bit from the truth rules of each mode.
  function automatic logic [W-1:0] ref_f(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                         input logic [W-1:0] fc, input logic [W-1:0] fd,
                                         input logic [1:0] fm);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      bit x, y, z, w;
      int ones;
      x = fa[i]; y = fb[i]; z = fc[i]; w = fd[i];
      ones = int'(x) + int'(y) + int'(z) + int'(w);
      case (fm)
        2'd0:    r[i] = !(((x && y) || !z) && w);
        2'd1:    r[i] = ((x && y) || !z) && w;
        2'd2:    r[i] = !((x && y) || (z && w));
        default: r[i] = (ones % 2) == 1;
      endcase
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample at the falling edge, check against the model,
  // update the model, then return just after the next rising edge.
  task automatic cycle();
    @(negedge clk);
    seen_ir = in_ready;
    oxfer   = 1'b0;
    if (rst) begin
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      hold_pending = 1'b0;
    end else begin
      check("in_ready", 32'(in_ready), 32'((q.size() < S) || out_ready));
      if (q.size() == 0) check("no_phantom", 32'(out_valid), 32'd0);
      if (hold_pending) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out), 32'(prev_out));
      end
      check("count", 32'(xfer_count), 32'(mcnt));
      if (out_valid && out_ready) begin
        oxfer = 1'b1;
        n_out++;
        ocyc.push_back(cyc);
        oval.push_back(out);
        if (q.size() > 0) check("data_order", 32'(out), 32'(q.pop_front()));
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_f(a, b, c, d, mode));
        n_in++;
      end
      if (count_clr) mcnt = 16'h0000;
      else if (oxfer && mcnt != 16'hFFFF) mcnt = mcnt + 16'h0001;
      hold_pending = out_valid && !out_ready;
      prev_out = out;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    a = W'($urandom); b = W'($urandom); c = W'($urandom); d = W'($urandom);
    mode = 2'($urandom_range(0, 3));
  endtask

  initial begin
    int start, guard, acc, base_out, base_in, base_cnt, k;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; count_clr = 1'b0;
    a = '0; b = '0; c = '0; d = '0; mode = 2'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", 32'(out), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_count", 32'(xfer_count), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    cycle();
    rst = 1'b0;
    #1;
    check("post_reset_in_ready", 32'(in_ready), 32'd1);

    // Single mode-0 input: latency and value
    out_ready = 1'b1;
    a = 8'hCC; b = 8'hAA; c = 8'h66; d = 8'hFF; mode = 2'd0;
    ocyc.delete(); oval.delete();
    start = cyc; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    guard = 0;
    while (ocyc.size() < 1 && guard < 20) begin cycle(); guard++; end
    check("lat1_seen", 32'(ocyc.size()), 32'd1);
    if (ocyc.size() >= 1) begin
      check("lat1", 32'(ocyc[0] - start), 32'(S));
      check("out_mode0", 32'(oval[0]), 32'h66);
    end
    check("count_after_first", 32'(xfer_count), 32'd1);

    // Modes 1..3 back to back at full throughput
    ocyc.delete(); oval.delete();
    start = cyc;
    for (int m = 1; m <= 3; m++) begin
      mode = 2'(m); in_valid = 1'b1;
      cycle();
      check("t2_in_ready", 32'(seen_ir), 32'd1);
    end
    in_valid = 1'b0;
    guard = 0;
    while (ocyc.size() < 3 && guard < 20) begin cycle(); guard++; end
    check("t2_seen", 32'(ocyc.size()), 32'd3);
    if (ocyc.size() >= 3) begin
      check("t2_lat", 32'(ocyc[0] - start), 32'(S));
      check("t2_gap1", 32'(ocyc[1] - ocyc[0]), 32'd1);
      check("t2_gap2", 32'(ocyc[2] - ocyc[1]), 32'd1);
      check("out_mode1", 32'(oval[0]), 32'h99);
      check("out_mode2", 32'(oval[1]), 32'h11);
      check("out_mode3", 32'(oval[2]), 32'hFF);
    end

    // Backpressure: 5 offers with the sink stalled, then release
    out_ready = 1'b0;
    base_out = n_out; base_cnt = int'(xfer_count);
    acc = 0;
    rand_ops();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      cycle();
      if (seen_ir) begin acc++; rand_ops(); end
    end
    check("bp_accepted", 32'(acc), 32'(S));
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    guard = 0;
    while (acc < 5 && guard < 50) begin
      cycle();
      if (seen_ir) begin acc++; rand_ops(); end
      guard++;
    end
    in_valid = 1'b0;
    guard = 0;
    while (q.size() > 0 && guard < 50) begin cycle(); guard++; end
    check("bp_outputs", 32'(n_out - base_out), 32'd5);
    check("bp_count", 32'(int'(xfer_count) - base_cnt), 32'd5);

    // Reset with two entries in flight
    out_ready = 1'b0;
    acc = 0; guard = 0;
    while (acc < 2 && guard < 20) begin
      rand_ops(); in_valid = 1'b1;
      cycle();
      if (seen_ir) acc++;
      guard++;
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out", 32'(out), 32'd0);
    check("midrst_count", 32'(xfer_count), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    q.delete(); mcnt = 16'h0000; hold_pending = 1'b0;
    cycle();
    rst = 1'b0;
    out_ready = 1'b1;
    ocyc.delete(); oval.delete();
    rand_ops();
    start = cyc; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    guard = 0;
    while (ocyc.size() < 1 && guard < 20) begin cycle(); guard++; end
    check("postrst_seen", 32'(ocyc.size()), 32'd1);
    if (ocyc.size() >= 1) check("postrst_lat", 32'(ocyc[0] - start), 32'(S));

    // Randomized valid/ready/clear traffic
    base_in = n_in; base_out = n_out;
    guard = 0;
    while ((n_in - base_in) < 2000 && guard < 20000) begin
      rand_ops();
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      count_clr = ($urandom_range(0, 63) == 0);
      cycle();
      guard++;
    end
    in_valid = 1'b0; out_ready = 1'b1; count_clr = 1'b0;
    guard = 0;
    while (q.size() > 0 && guard < 50) begin cycle(); guard++; end
    check("rand_in_total", 32'(n_in - base_in), 32'd2000);
    check("rand_balance", 32'(n_out - base_out), 32'(n_in - base_in));
    check("rand_count", 32'(xfer_count), 32'(mcnt));

    // Counter saturation and clear priority
    count_clr = 1'b1;
    cycle();
    count_clr = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    guard = 0;
    while (mcnt != 16'hFFFE && guard < 70000) begin cycle(); guard++; end
    check("pre_sat", 32'(xfer_count), 32'hFFFE);
    k = n_out; guard = 0;
    while ((n_out - k) < 3 && guard < 20) begin cycle(); guard++; end
    check("sat_transfers", 32'(n_out - k), 32'd3);
    check("sat", 32'(xfer_count), 32'hFFFF);
    count_clr = 1'b1;
    cycle();
    count_clr = 1'b0;
    check("clr_concurrent_xfer", 32'(oxfer), 32'd1);
    check("clr", 32'(xfer_count), 32'd0);
    in_valid = 1'b0;
    guard = 0;
    while (q.size() > 0 && guard < 50) begin cycle(); guard++; end
    check("final_drain", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
